// File: rtl/oam_dma_pkg.sv
// Shared constants, state encoding and echo-fold helper for the OAM DMA engine.
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          DMA_LEN      = 160;
  localparam logic [7:0]  ECHO_FOLD_HI = 8'hE0;
  localparam logic [7:0]  LAST_IDX     = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  // Sources in the echo region E000-FFFF are fetched from their C000-DFFF mirror.
  function automatic logic [7:0] fold_hi(input logic [7:0] hi);
    return (hi >= ECHO_FOLD_HI) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: owns FF46, copies 160 bytes {src_hi,00..9F} -> FE00..FE9F, 1 + 2/byte cycles.
// CPU bus passes through combinationally when idle; CPU accesses are dropped while DMA owns the bus.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Do_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  output logic [7:0]  Di_cpu,
  output logic [15:0] A_mmu,
  output logic [7:0]  Do_mmu,
  output logic        wr_mmu,
  output logic        rd_mmu,
  input  logic [7:0]  Di_mmu,
  output logic        dma_active
);

  dma_state_t state;
  logic [7:0] src_hi;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic [7:0] eff_hi;
  logic       reg_hit;

  assign reg_hit    = (A_cpu == DMA_REG_ADDR);
  assign eff_hi     = fold_hi(src_hi);
  assign dma_active = (state != IDLE);

  // A register write outranks every state, so it restarts even on the final WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      src_hi <= 8'h00;
      idx    <= 8'h00;
      data_q <= 8'h00;
    end else if (wr_cpu && reg_hit) begin
      state  <= START;
      src_hi <= Do_cpu;
      idx    <= 8'h00;
    end else begin
      case (state)
        IDLE:  state <= IDLE;
        START: state <= READ;
        READ: begin
          data_q <= Di_mmu;
          state  <= WRITE;
        end
        WRITE: begin
          idx   <= idx + 8'h01;
          state <= (idx == LAST_IDX) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    A_mmu  = A_cpu;
    Do_mmu = Do_cpu;
    wr_mmu = wr_cpu;
    rd_mmu = rd_cpu;
    Di_cpu = Di_mmu;
    case (state)
      IDLE: begin
        if (reg_hit) begin
          wr_mmu = 1'b0;
          rd_mmu = 1'b0;
        end
      end
      START: begin
        A_mmu  = {eff_hi, idx};
        Do_mmu = 8'h00;
        wr_mmu = 1'b0;
        rd_mmu = 1'b0;
        Di_cpu = 8'hFF;
      end
      READ: begin
        A_mmu  = {eff_hi, idx};
        Do_mmu = 8'h00;
        wr_mmu = 1'b0;
        rd_mmu = 1'b1;
        Di_cpu = 8'hFF;
      end
      WRITE: begin
        A_mmu  = OAM_BASE + {8'h00, idx};
        Do_mmu = data_q;
        wr_mmu = 1'b1;
        rd_mmu = 1'b0;
        Di_cpu = 8'hFF;
      end
      default: begin
        wr_mmu = 1'b0;
        rd_mmu = 1'b0;
      end
    endcase
    if (reg_hit) Di_cpu = src_hi;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: memory-map model, idle vector table, per-cycle transfer model, corner sequences.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A_cpu;
  logic [7:0]  Do_cpu;
  logic        wr_cpu;
  logic        rd_cpu;
  logic [7:0]  Di_cpu;
  logic [15:0] A_mmu;
  logic [7:0]  Do_mmu;
  logic        wr_mmu;
  logic        rd_mmu;
  logic [7:0]  Di_mmu;
  logic        dma_active;

  int errors = 0;
  int checks = 0;
  int bad_strobe;
  int bad_k;
  int bad_di;

  logic [7:0] mem [0:65535];
  logic [7:0] img [0:159];
  logic [7:0] oam_ref [0:159];

  always #5 clk = ~clk;

  oam_dma dut (
    .clk(clk), .rst(rst),
    .A_cpu(A_cpu), .Do_cpu(Do_cpu), .wr_cpu(wr_cpu), .rd_cpu(rd_cpu), .Di_cpu(Di_cpu),
    .A_mmu(A_mmu), .Do_mmu(Do_mmu), .wr_mmu(wr_mmu), .rd_mmu(rd_mmu), .Di_mmu(Di_mmu),
    .dma_active(dma_active)
  );

  assign Di_mmu = mem[A_mmu];
  always @(posedge clk) if (wr_mmu) mem[A_mmu] = Do_mmu;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        wr;
    logic        rd;
    logic [7:0]  exp_di;
    logic [15:0] exp_a;
    logic [7:0]  exp_do;
    logic        exp_wr;
    logic        exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  task automatic idle_in();
    A_cpu = 16'h0000; Do_cpu = 8'h00; wr_cpu = 1'b0; rd_cpu = 1'b0;
  endtask

  task automatic fill(input logic [7:0] eff, input bit ramp);
    for (int j = 0; j < 160; j++) begin
      img[j] = ramp ? 8'(j) : 8'($urandom);
      mem[{eff, 8'(j)}] = img[j];
    end
  endtask

  task automatic start_dma(input logic [7:0] src);
    A_cpu = 16'hFF46; Do_cpu = src; wr_cpu = 1'b1; rd_cpu = 1'b0;
    @(posedge clk); #1;
    idle_in();
    bad_strobe = 0; bad_k = -1; bad_di = 0;
  endtask

  // Active cycle k: 0 is the setup cycle, then odd k reads byte (k-1)/2 and even k writes it.
  task automatic run_active(input logic [7:0] src, input int k0, input int k1, input int mode);
    logic [7:0]  eff;
    logic        ew, er;
    logic [15:0] ea;
    logic [7:0]  edo;
    int          j;
    eff = fold(src);
    for (int k = k0; k < k1; k++) begin
      if (mode == 1) begin
        A_cpu = 16'($urandom);
        if (A_cpu == 16'hFF46) A_cpu = 16'hC000;
        Do_cpu = 8'($urandom); wr_cpu = 1'($urandom); rd_cpu = 1'($urandom);
      end else if (mode == 2) begin
        if (k % 2 == 0) begin A_cpu = 16'hC000; Do_cpu = 8'h77; wr_cpu = 1'b1; rd_cpu = 1'b0; end
        else            begin A_cpu = 16'h0000; Do_cpu = 8'h00; wr_cpu = 1'b0; rd_cpu = 1'b1; end
      end
      ew = 1'b0; er = 1'b0; ea = 16'h0000; edo = 8'h00;
      j = (k - 1) / 2;
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin er = 1'b1; ea = {eff, 8'(j)}; end
        else begin ew = 1'b1; ea = 16'hFE00 + 16'(j); edo = img[j]; end
      end
      @(negedge clk);
      if (dma_active !== 1'b1 || wr_mmu !== ew || rd_mmu !== er || Do_mmu !== edo ||
          (k > 0 && A_mmu !== ea)) begin
        if (bad_strobe == 0) bad_k = k;
        bad_strobe++;
      end
      if (mode != 0 && Di_cpu !== 8'hFF) bad_di++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_oam(input string name);
    int bad = 0;
    for (int j = 0; j < 160; j++)
      if (mem[16'hFE00 + 16'(j)] !== oam_ref[j]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic finish_checks(input string tag);
    @(negedge clk);
    check({tag, "_idle_after"}, {31'd0, dma_active}, 32'd0);
    if (bad_strobe != 0) $display("first bad active cycle in %s: %0d", tag, bad_k);
    check({tag, "_bus_seq"}, 32'(bad_strobe), 32'd0);
    check_oam({tag, "_oam"});
    @(posedge clk); #1;
  endtask

  vec_t vecs [6];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int j = 0; j < 160; j++) begin
      oam_ref[j] = 8'($urandom);
      mem[16'hFE00 + 16'(j)] = oam_ref[j];
    end
    mem[16'hC005] = 8'h5A; mem[16'hC010] = 8'h11; mem[16'h1234] = 8'h42;
    mem[16'h0000] = 8'h07; mem[16'hC000] = 8'h5E;

    vecs[0] = '{16'hC005, 8'h00, 1'b0, 1'b1, 8'h5A, 16'hC005, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{16'hC010, 8'h3C, 1'b1, 1'b0, 8'h11, 16'hC010, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{16'hC010, 8'h00, 1'b0, 1'b1, 8'h3C, 16'hC010, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'h00, 16'hFF46, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 8'h99, 1'b0, 1'b0, 8'h42, 16'h1234, 8'h99, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h07, 16'h0000, 8'h00, 1'b0, 1'b1};

    rst = 1'b1; idle_in();
    A_cpu = 16'hFF46; rd_cpu = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_active", {31'd0, dma_active}, 32'd0);
    check("reset_ff46", {24'd0, Di_cpu}, 32'h00);
    check("reset_strobes", {30'd0, wr_mmu, rd_mmu}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      A_cpu = vecs[i].a; Do_cpu = vecs[i].d; wr_cpu = vecs[i].wr; rd_cpu = vecs[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {Di_cpu, A_mmu, wr_mmu, rd_mmu, 6'd0},
            {vecs[i].exp_di, vecs[i].exp_a, vecs[i].exp_wr, vecs[i].exp_rd, 6'd0});
      check($sformatf("vec%0d_do", i), {24'd0, Do_mmu}, {24'd0, vecs[i].exp_do});
      @(posedge clk); #1;
    end
    idle_in();

    // Basic ramp transfer from C100.
    fill(8'hC1, 1'b1);
    start_dma(8'hC1);
    run_active(8'hC1, 0, 321, 0);
    for (int j = 0; j < 160; j++) oam_ref[j] = img[j];
    finish_checks("ramp_c1");

    // Register readback while the transfer it launched is in its setup cycle.
    fill(8'h80, 1'b0);
    start_dma(8'h80);
    A_cpu = 16'hFF46; rd_cpu = 1'b1;
    @(negedge clk);
    check("ff46_readback", {24'd0, Di_cpu}, 32'h80);
    check("ff46_not_forwarded", {31'd0, rd_mmu}, 32'd0);
    @(posedge clk); #1;
    idle_in();
    run_active(8'h80, 1, 321, 0);
    for (int j = 0; j < 160; j++) oam_ref[j] = img[j];
    finish_checks("src_80");

    // CPU traffic during DMA is dropped.
    fill(8'hC4, 1'b0);
    start_dma(8'hC4);
    run_active(8'hC4, 0, 321, 2);
    idle_in();
    check("cpu_di_blocked", 32'(bad_di), 32'd0);
    check("c000_unchanged", {24'd0, mem[16'hC000]}, 32'h5E);
    for (int j = 0; j < 160; j++) oam_ref[j] = img[j];
    finish_checks("blocked");

    // Restart at active cycle 50 (a WRITE of byte 24): that byte still lands, then a fresh run from C200.
    fill(8'hC1, 1'b0);
    start_dma(8'hC1);
    run_active(8'hC1, 0, 50, 0);
    A_cpu = 16'hFF46; Do_cpu = 8'hC2; wr_cpu = 1'b1;
    run_active(8'hC1, 50, 51, 0);
    idle_in();
    for (int j = 0; j < 25; j++) oam_ref[j] = img[j];
    fill(8'hC2, 1'b0);
    run_active(8'hC2, 0, 321, 0);
    for (int j = 0; j < 160; j++) oam_ref[j] = img[j];
    finish_checks("restart");

    // Echo fold: E1 sources from C100.
    fill(fold(8'hE1), 1'b0);
    start_dma(8'hE1);
    run_active(8'hE1, 0, 321, 1);
    idle_in();
    check("echo_di_blocked", 32'(bad_di), 32'd0);
    for (int j = 0; j < 160; j++) oam_ref[j] = img[j];
    finish_checks("echo_e1");

    // Reset during active cycle 100 (WRITE of byte 49).
    fill(8'hC3, 1'b0);
    start_dma(8'hC3);
    run_active(8'hC3, 0, 100, 0);
    rst = 1'b1;
    run_active(8'hC3, 100, 101, 0);
    rst = 1'b0;
    check("pre_reset_seq", 32'(bad_strobe), 32'd0);
    A_cpu = 16'hFF46; rd_cpu = 1'b1;
    @(negedge clk);
    check("rst_mid_active", {31'd0, dma_active}, 32'd0);
    check("rst_mid_strobes", {30'd0, wr_mmu, rd_mmu}, 32'd0);
    check("rst_mid_ff46", {24'd0, Di_cpu}, 32'h00);
    @(posedge clk); #1;
    idle_in();
    bad_strobe = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wr_mmu !== 1'b0 || rd_mmu !== 1'b0 || dma_active !== 1'b0) bad_strobe++;
      @(posedge clk); #1;
    end
    check("rst_quiet_after", 32'(bad_strobe), 32'd0);
    for (int j = 0; j < 50; j++) oam_ref[j] = img[j];
    check_oam("rst_oam_retained");

    // Random sources with random CPU noise on the bus.
    for (int t = 0; t < 4; t++) begin
      logic [7:0] s;
      s = 8'($urandom);
      fill(fold(s), 1'b0);
      start_dma(s);
      run_active(s, 0, 321, 1);
      idle_in();
      check($sformatf("rand%0d_di_blocked", t), 32'(bad_di), 32'd0);
      for (int j = 0; j < 160; j++) oam_ref[j] = img[j];
      finish_checks($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
